// File: rtl/arqui_pkg.sv
// arqui_pkg: shared state encoding, FIFO indices and default widths for the arqui control slice.
// Rev 1.0
`default_nettype none

package arqui_pkg;

  localparam int MF_TH_W_DEF = 2;
  localparam int VC_TH_W_DEF = 4;
  localparam int DF_TH_W_DEF = 2;
  localparam int N_FIFO_DEF  = 5;

  // Bit positions inside fifo_empty / fifo_err / error_out
  localparam int IDX_MAIN = 0;
  localparam int IDX_VC0  = 1;
  localparam int IDX_VC1  = 2;
  localparam int IDX_D0   = 3;
  localparam int IDX_D1   = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/arqui_th_regs.sv
// arqui_th_regs: threshold register bank with af>ae validity check on the set being loaded.
// Rev 1.0
`default_nettype none

module arqui_th_regs #(
  parameter int MF_TH_W = 2,
  parameter int VC_TH_W = 4,
  parameter int DF_TH_W = 2
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               load_i,
  input  logic [MF_TH_W-1:0] afMF_i,
  input  logic [MF_TH_W-1:0] aeMF_i,
  input  logic [VC_TH_W-1:0] afVC_i,
  input  logic [VC_TH_W-1:0] aeVC_i,
  input  logic [DF_TH_W-1:0] afDF_i,
  input  logic [DF_TH_W-1:0] aeDF_i,
  output logic [MF_TH_W-1:0] afMF_o,
  output logic [MF_TH_W-1:0] aeMF_o,
  output logic [VC_TH_W-1:0] afVC_o,
  output logic [VC_TH_W-1:0] aeVC_o,
  output logic [DF_TH_W-1:0] afDF_o,
  output logic [DF_TH_W-1:0] aeDF_o,
  output logic               cfg_valid_o
);

  logic [MF_TH_W-1:0] afMF_q, aeMF_q;
  logic [VC_TH_W-1:0] afVC_q, aeVC_q;
  logic [DF_TH_W-1:0] afDF_q, aeDF_q;

  // Validity refers to the inputs so the FSM can judge the set captured on this same edge
  assign cfg_valid_o = (afMF_i > aeMF_i) && (afVC_i > aeVC_i) && (afDF_i > aeDF_i);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      afMF_q <= '0;
      aeMF_q <= '0;
      afVC_q <= '0;
      aeVC_q <= '0;
      afDF_q <= '0;
      aeDF_q <= '0;
    end else if (load_i) begin
      afMF_q <= afMF_i;
      aeMF_q <= aeMF_i;
      afVC_q <= afVC_i;
      aeVC_q <= aeVC_i;
      afDF_q <= afDF_i;
      aeDF_q <= aeDF_i;
    end
  end

  assign afMF_o = afMF_q;
  assign aeMF_o = aeMF_q;
  assign afVC_o = afVC_q;
  assign aeVC_o = aeVC_q;
  assign afDF_o = afDF_q;
  assign aeDF_o = aeDF_q;

endmodule

`default_nettype wire

// File: rtl/arqui_ctrl_fsm.sv
// arqui_ctrl_fsm: control FSM for the arqui datapath; threshold distribution, occupancy and sticky error tracking.
// Rev 1.0
`default_nettype none

module arqui_ctrl_fsm
  import arqui_pkg::*;
#(
  parameter int MF_TH_W = MF_TH_W_DEF,
  parameter int VC_TH_W = VC_TH_W_DEF,
  parameter int DF_TH_W = DF_TH_W_DEF,
  parameter int N_FIFO  = N_FIFO_DEF
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [MF_TH_W-1:0] afMF_i,
  input  logic [MF_TH_W-1:0] aeMF_i,
  input  logic [VC_TH_W-1:0] afVC_i,
  input  logic [VC_TH_W-1:0] aeVC_i,
  input  logic [DF_TH_W-1:0] afDF_i,
  input  logic [DF_TH_W-1:0] aeDF_i,
  input  logic [N_FIFO-1:0]  fifo_empty,
  input  logic [N_FIFO-1:0]  fifo_err,
  output logic [MF_TH_W-1:0] afMF_o,
  output logic [MF_TH_W-1:0] aeMF_o,
  output logic [VC_TH_W-1:0] afVC_o,
  output logic [VC_TH_W-1:0] aeVC_o,
  output logic [DF_TH_W-1:0] afDF_o,
  output logic [DF_TH_W-1:0] aeDF_o,
  output logic               idle_out,
  output logic               active_out,
  output logic [N_FIFO-1:0]  error_out,
  output logic               cfg_error,
  output logic [2:0]         state_o
);

  state_e            state_q;
  logic              idle_q;
  logic              active_q;
  logic              cfg_err_q;
  logic [N_FIFO-1:0] err_q;
  logic              cfg_valid;
  logic              th_load;

  assign th_load = (state_q == ST_INIT);

  arqui_th_regs #(
    .MF_TH_W (MF_TH_W),
    .VC_TH_W (VC_TH_W),
    .DF_TH_W (DF_TH_W)
  ) u_th_regs (
    .clk         (clk),
    .reset_L     (reset_L),
    .load_i      (th_load),
    .afMF_i      (afMF_i),
    .aeMF_i      (aeMF_i),
    .afVC_i      (afVC_i),
    .aeVC_i      (aeVC_i),
    .afDF_i      (afDF_i),
    .aeDF_i      (aeDF_i),
    .afMF_o      (afMF_o),
    .aeMF_o      (aeMF_o),
    .afVC_o      (afVC_o),
    .aeVC_o      (aeVC_o),
    .afDF_o      (afDF_o),
    .aeDF_o      (aeDF_o),
    .cfg_valid_o (cfg_valid)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_RESET;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q  <= ST_INIT;
          idle_q   <= 1'b0;
          active_q <= 1'b0;
        end
        ST_INIT: begin
          cfg_err_q <= !cfg_valid;
          if (!init && cfg_valid) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          // Error outranks a re-init request arriving in the same cycle
          if (|fifo_err) begin
            state_q  <= ST_ERROR;
            idle_q   <= 1'b0;
            active_q <= 1'b0;
            err_q    <= err_q | fifo_err;
          end else if (init) begin
            state_q  <= ST_INIT;
            idle_q   <= 1'b0;
            active_q <= 1'b0;
          end else if (&fifo_empty) begin
            state_q  <= ST_IDLE;
            idle_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            state_q  <= ST_ACTIVE;
            idle_q   <= 1'b0;
            active_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          idle_q   <= 1'b0;
          active_q <= 1'b0;
          err_q    <= err_q | fifo_err;
        end
        default: begin
          state_q  <= ST_RESET;
          idle_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = err_q;
  assign cfg_error  = cfg_err_q;
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_arqui_ctrl_fsm.sv
// tb_arqui_ctrl_fsm: vector table, hand-written corner sequences and randomized run against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_arqui_ctrl_fsm;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [1:0] afMF_i, aeMF_i, afDF_i, aeDF_i;
  logic [3:0] afVC_i, aeVC_i;
  logic [4:0] fifo_empty, fifo_err;
  logic [1:0] afMF_o, aeMF_o, afDF_o, aeDF_o;
  logic [3:0] afVC_o, aeVC_o;
  logic       idle_out, active_out, cfg_error;
  logic [4:0] error_out;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  arqui_ctrl_fsm dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .afMF_i     (afMF_i),
    .aeMF_i     (aeMF_i),
    .afVC_i     (afVC_i),
    .aeVC_i     (aeVC_i),
    .afDF_i     (afDF_i),
    .aeDF_i     (aeDF_i),
    .fifo_empty (fifo_empty),
    .fifo_err   (fifo_err),
    .afMF_o     (afMF_o),
    .aeMF_o     (aeMF_o),
    .afVC_o     (afVC_o),
    .aeVC_o     (aeVC_o),
    .afDF_o     (afDF_o),
    .aeDF_o     (aeDF_o),
    .idle_out   (idle_out),
    .active_out (active_out),
    .error_out  (error_out),
    .cfg_error  (cfg_error),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ini;
    logic [15:0] th;
    logic [4:0]  emp;
    logic [4:0]  err;
    logic [2:0]  e_st;
    logic        e_idle;
    logic        e_act;
    logic [4:0]  e_err;
    logic        e_cfg;
    logic [15:0] e_th;
  } vec_t;

  vec_t tbl[29];

  function automatic logic [15:0] th(input int afm, aem, afv, aev, afd, aed);
    logic [1:0] a, b, e, f;
    logic [3:0] c, d;
    a = 2'(afm); b = 2'(aem); c = 4'(afv); d = 4'(aev); e = 2'(afd); f = 2'(aed);
    return {a, b, c, d, e, f};
  endfunction

  function automatic vec_t mk(input logic rst, ini, input logic [15:0] t, input logic [4:0] emp, err,
                              input int st, input logic idl, act, input logic [4:0] eer,
                              input logic cfg, input logic [15:0] eth);
    vec_t v;
    v.rst = rst; v.ini = ini; v.th = t; v.emp = emp; v.err = err;
    v.e_st = 3'(st); v.e_idle = idl; v.e_act = act; v.e_err = eer; v.e_cfg = cfg; v.e_th = eth;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] th_out();
    return {afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o};
  endfunction

  task automatic drive(input logic rst, ini, input logic [15:0] t, input logic [4:0] emp, err);
    reset_L = rst;
    init = ini;
    {afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i} = t;
    fifo_empty = emp;
    fifo_err = err;
  endtask

  // Behavioural reference: phase numbers follow the published state encoding
  int          m_phase;
  logic [15:0] m_th;
  logic [4:0]  m_err;
  logic        m_cfg;

  task automatic model_reset();
    m_phase = 0; m_th = '0; m_err = '0; m_cfg = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] t;
    bit ok;
    t = {afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i};
    if (!reset_L) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      ok = (t[15:14] > t[13:12]) && (t[11:8] > t[7:4]) && (t[3:2] > t[1:0]);
      m_th = t;
      m_cfg = !ok;
      if (ok && !init) m_phase = 2;
    end else if (m_phase == 4) begin
      m_err = m_err | fifo_err;
    end else if (fifo_err != 0) begin
      m_phase = 4;
      m_err = fifo_err;
    end else if (init) begin
      m_phase = 1;
    end else begin
      m_phase = (fifo_empty == 5'b11111) ? 2 : 3;
    end
  endtask

  task automatic check_model();
    chk("rnd_state", 32'(state_o), 32'(m_phase));
    chk("rnd_flags", {29'd0, idle_out, active_out, cfg_error},
        {29'd0, (m_phase == 2), (m_phase == 3), m_cfg});
    chk("rnd_err", 32'(error_out), 32'(m_err));
    chk("rnd_th", 32'(th_out()), 32'(m_th));
  endtask

  function automatic logic [15:0] rand_th();
    int ae_m, af_m, ae_v, af_v, ae_d, af_d;
    if ($urandom_range(0, 3) != 0) begin
      ae_m = $urandom_range(0, 2); af_m = $urandom_range(ae_m + 1, 3);
      ae_v = $urandom_range(0, 14); af_v = $urandom_range(ae_v + 1, 15);
      ae_d = $urandom_range(0, 2); af_d = $urandom_range(ae_d + 1, 3);
    end else begin
      af_m = $urandom_range(0, 3); ae_m = $urandom_range(0, 3);
      af_v = $urandom_range(0, 15); ae_v = $urandom_range(0, 15);
      af_d = $urandom_range(0, 3); ae_d = $urandom_range(0, 3);
    end
    return th(af_m, ae_m, af_v, ae_v, af_d, ae_d);
  endfunction

  logic [15:0] TA, TB, TI, TV, TM, TD;

  initial begin
    TA = th(3, 1, 14, 2, 3, 1);
    TB = th(2, 0, 9, 1, 2, 0);
    TI = th(3, 1, 2, 2, 3, 1);
    TV = th(3, 1, 9, 2, 3, 1);
    TM = th(1, 1, 14, 2, 3, 1);
    TD = th(3, 1, 14, 2, 1, 3);

    tbl[0]  = mk(0, 0, TA, 5'h1F, 5'h00, 0, 0, 0, 5'h00, 0, 16'h0);
    tbl[1]  = mk(0, 0, TA, 5'h1F, 5'h00, 0, 0, 0, 5'h00, 0, 16'h0);
    tbl[2]  = mk(0, 0, TA, 5'h1F, 5'h00, 0, 0, 0, 5'h00, 0, 16'h0);
    tbl[3]  = mk(1, 0, TA, 5'h1F, 5'h1F, 1, 0, 0, 5'h00, 0, 16'h0);
    tbl[4]  = mk(1, 0, TA, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TA);
    tbl[5]  = mk(1, 0, TA, 5'h1E, 5'h00, 3, 0, 1, 5'h00, 0, TA);
    tbl[6]  = mk(1, 0, TA, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TA);
    tbl[7]  = mk(1, 0, TA, 5'h1E, 5'h00, 3, 0, 1, 5'h00, 0, TA);
    tbl[8]  = mk(1, 0, TA, 5'h1E, 5'h08, 4, 0, 0, 5'h08, 0, TA);
    tbl[9]  = mk(1, 0, TA, 5'h1E, 5'h00, 4, 0, 0, 5'h08, 0, TA);
    tbl[10] = mk(1, 0, TA, 5'h1E, 5'h01, 4, 0, 0, 5'h09, 0, TA);
    tbl[11] = mk(1, 1, TA, 5'h1F, 5'h00, 4, 0, 0, 5'h09, 0, TA);
    tbl[12] = mk(1, 1, TB, 5'h1F, 5'h00, 4, 0, 0, 5'h09, 0, TA);
    tbl[13] = mk(0, 0, TA, 5'h1F, 5'h00, 0, 0, 0, 5'h00, 0, 16'h0);
    tbl[14] = mk(1, 0, TA, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 0, 16'h0);
    tbl[15] = mk(1, 0, TA, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TA);
    tbl[16] = mk(1, 1, TA, 5'h1F, 5'h02, 4, 0, 0, 5'h02, 0, TA);
    tbl[17] = mk(0, 0, TI, 5'h1F, 5'h00, 0, 0, 0, 5'h00, 0, 16'h0);
    tbl[18] = mk(1, 0, TI, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 0, 16'h0);
    tbl[19] = mk(1, 0, TI, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 1, TI);
    tbl[20] = mk(1, 0, TI, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 1, TI);
    tbl[21] = mk(1, 0, TV, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TV);
    tbl[22] = mk(1, 1, TB, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 0, TV);
    tbl[23] = mk(1, 1, TB, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 0, TB);
    tbl[24] = mk(1, 0, TB, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TB);
    tbl[25] = mk(1, 1, TM, 5'h1F, 5'h00, 1, 0, 0, 5'h00, 0, TB);
    tbl[26] = mk(1, 0, TM, 5'h1F, 5'h1F, 1, 0, 0, 5'h00, 1, TM);
    tbl[27] = mk(1, 0, TD, 5'h00, 5'h00, 1, 0, 0, 5'h00, 1, TD);
    tbl[28] = mk(1, 0, TA, 5'h1F, 5'h00, 2, 1, 0, 5'h00, 0, TA);

    drive(1'b0, 1'b0, TA, 5'h1F, 5'h00);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ini, tbl[i].th, tbl[i].emp, tbl[i].err);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].e_st));
      chk($sformatf("vec%0d_flags", i), {29'd0, idle_out, active_out, cfg_error},
          {29'd0, tbl[i].e_idle, tbl[i].e_act, tbl[i].e_cfg});
      chk($sformatf("vec%0d_err", i), 32'(error_out), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d_th", i), 32'(th_out()), 32'(tbl[i].e_th));
    end

    // Asynchronous reset while ACTIVE must clear outputs before the next edge
    @(negedge clk);
    drive(1'b1, 1'b0, TA, 5'h1E, 5'h00);
    @(posedge clk);
    #1;
    chk("mid_active_state", 32'(state_o), 32'd3);
    chk("mid_active_afMF", 32'(afMF_o), 32'd3);
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_flags", {29'd0, idle_out, active_out, cfg_error}, 32'd0);
    chk("async_err", 32'(error_out), 32'd0);
    chk("async_th", 32'(th_out()), 32'd0);

    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 7) == 0),
            rand_th(),
            ($urandom_range(0, 1) == 0) ? 5'h1F : 5'($urandom),
            ($urandom_range(0, 23) == 0) ? 5'($urandom) : 5'h00);
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arqui_ctrl_fsm.md
Name: arqui_ctrl_fsm

Overview:
- Control state machine for the arqui datapath: main FIFO → VC0/VC1 FIFOs → D0/D1 FIFOs.
- Captures the almost-full/almost-empty thresholds and distributes registered copies to the five FIFOs.
- Tracks FIFO occupancy and error flags; produces the idle_out, active_out and error_out status consumed by the test bench.
- Sits beside the datapath, fed by the stimulus stage: it consumes the init/threshold inputs and the FIFO flags.

Parameters:
- MF_TH_W, 2, width of main-FIFO thresholds
- VC_TH_W, 4, width of VC-FIFO thresholds
- DF_TH_W, 2, width of D-FIFO thresholds
- N_FIFO, 5, number of monitored FIFOs; bit order is main, VC0, VC1, D0, D1 (bit 0 = main)

Ports:
- clk  in  1  single system clock, all state on posedge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  request re-initialisation/threshold capture
- afMF_i  in  MF_TH_W  main almost-full threshold
- aeMF_i  in  MF_TH_W  main almost-empty threshold
- afVC_i  in  VC_TH_W  VC almost-full threshold
- aeVC_i  in  VC_TH_W  VC almost-empty threshold
- afDF_i  in  DF_TH_W  D almost-full threshold
- aeDF_i  in  DF_TH_W  D almost-empty threshold
- fifo_empty  in  N_FIFO  per-FIFO empty flags
- fifo_err  in  N_FIFO  per-FIFO overflow/underflow pulse
- afMF_o, aeMF_o  out  MF_TH_W  registered thresholds to main FIFO
- afVC_o, aeVC_o  out  VC_TH_W  registered thresholds to VC FIFOs
- afDF_o, aeDF_o  out  DF_TH_W  registered thresholds to D FIFOs
- idle_out  out  1  high in IDLE
- active_out  out  1  high in ACTIVE
- error_out  out  N_FIFO  sticky per-FIFO error record
- cfg_error  out  1  captured thresholds invalid
- state_o  out  3  one-hot-free encoded current state, for debug

Behaviour:
- Reset (reset_L=0, asynchronous): state=RESET; all *_o thresholds=0, idle_out=0, active_out=0, error_out=0, cfg_error=0.
- All outputs are registered (Moore); each changes on the clock edge that enters the corresponding state.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET → INIT on the first posedge with reset_L=1, unconditionally.
- INIT:
  - Every cycle, thresholds load from the *_i inputs into the *_o registers.
  - Valid configuration requires af > ae (unsigned) for all three pairs.
  - Leave to IDLE when init=0 and the just-captured set is valid.
  - If invalid: stay in INIT with cfg_error=1; cfg_error clears on the cycle a valid set is captured.
  - Thresholds are therefore stable at the *_o ports 2 cycles after reset release with init=0.
- IDLE / ACTIVE transition priority (highest first):
  1. Any fifo_err bit set → ERROR.
  2. init=1 → INIT.
  3. IDLE → ACTIVE if any fifo_empty bit is 0; ACTIVE → IDLE if fifo_empty is all-ones.
- Thresholds hold their value outside INIT; init only re-captures them.
- ERROR:
  - error_out |= fifo_err every cycle, including the entry cycle, so error_out equals the triggering bits on entry.
  - idle_out=0, active_out=0.
  - Exit is by reset_L only; init is ignored.
- fifo_err in RESET or INIT is ignored and not recorded.
- Simultaneous error and init in IDLE/ACTIVE: ERROR wins.
- Reset asserted in any state, including mid-ACTIVE, returns every output to its reset value immediately, without waiting for a clock edge.
- No arithmetic beyond unsigned compares; compares are width-matched per pair, with no cross-width comparison.
- Target size: about 150–250 lines of RTL.

Decomposition:
- Shared package arqui_pkg holds:
  - state encoding constants (ST_RESET … ST_ERROR);
  - FIFO index constants (IDX_MAIN=0, IDX_VC0=1, IDX_VC1=2, IDX_D0=3, IDX_D1=4);
  - default threshold widths.
- One sub-module, arqui_th_regs: threshold register bank plus af>ae validity compare, with load-enable driven by the FSM.
- The FSM and the error accumulator stay in the top module.

Test Plan:
- Reset values: hold reset_L=0 for 3 cycles → all outputs 0, state_o=0; release with af/ae = MF 3/1, VC 14/2, DF 3/1 and init=0 → state_o=1 after 1 edge, =2 after 2 edges; *_o equal these inputs; idle_out=1 with fifo_empty=5'b11111.
- Occupancy tracking: from IDLE, fifo_empty=5'b11110 → next edge active_out=1, idle_out=0; return fifo_empty=5'b11111 → next edge idle_out=1.
- Sticky error: in ACTIVE, pulse fifo_err=5'b01000 for 1 cycle, then 5'b00001 later → error_out=5'b01000, then 5'b01001; state_o stays 4 through init=1; reset_L=0 clears to 0 asynchronously.
- Priority: same cycle fifo_err=5'b00010 and init=1 from IDLE → state_o=4, error_out=5'b00010, thresholds unchanged.
- Invalid configuration: reset with afVC_i=2, aeVC_i=2 → state_o stays 1 and cfg_error=1; change afVC_i to 9 → cfg_error=0, IDLE on the next edge, afVC_o=9.
- Reset mid-operation: in ACTIVE with afMF_o=3, assert reset_L=0 between clock edges → all outputs 0 before the next posedge.
